hpu_task_frontend: RTL
======================

Name: hpu_task_frontend

Overview:
- Per-HPU endpoint of the cluster-scheduler-to-HPU task and feedback interface.
- Accepts one hpu_handler_task_t from the cluster scheduler and presents it to the core runtime.
- Times handler execution and enforces an optional watchdog.
- Returns task_feedback_descr_t to the cluster scheduler through a small feedback FIFO, so the HPU can take the next task while earlier feedback is still waiting for grant.

Parameters:
- FB_FIFO_DEPTH, 2: feedback FIFO entries; minimum 1.
- MAX_HANDLER_CYCLES, 0: watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- hpu_task_valid_i  in  1  task offered by the cluster scheduler.
- hpu_task_ready_o  out  1  frontend can accept a task.
- hpu_task_i  in  hpu_handler_task_t  task descriptor.
- hpu_feedback_valid_o  out  1  feedback available.
- hpu_feedback_ready_i  in  1  cluster feedback arbiter grant.
- hpu_feedback_o  out  task_feedback_descr_t  feedback descriptor.
- hpu_active_o  out  1  frontend busy.
- core_task_valid_o  out  1  task pending for the core runtime.
- core_task_o  out  hpu_handler_task_t  registered task.
- core_task_ack_i  in  1  runtime has taken the task and started the handler.
- core_done_i  in  1  single-cycle pulse: handler finished.
- timeout_o  out  1  sticky flag: watchdog fired.
- last_cycles_o  out  32  duration of the last completed handler.

Behaviour:
- Reset values: core_task_o = 0, timeout_o = 0, last_cycles_o = 0, FIFO empty, state = Idle.
  - From that, all valid outputs and hpu_active_o are 0, and hpu_task_ready_o = 1.
- An asynchronous reset mid-operation discards the held task, the cycle count and all FIFO contents.
- State machine: Idle, Dispatch, Run, Stall.
  - Idle: hpu_task_ready_o = 1. On hpu_task_valid_i && ready, register hpu_task_i into core_task_o and go to Dispatch.
  - Dispatch: core_task_valid_o = 1. On core_task_ack_i, clear the cycle counter to 0 and go to Run. core_done_i is ignored in this state.
  - Run: the counter increments by 1 every cycle and saturates at 32'hFFFF_FFFF.
    - On core_done_i, the handler completes.
    - If MAX_HANDLER_CYCLES != 0 and the counter reaches MAX_HANDLER_CYCLES-1 without core_done_i, the handler completes by timeout and timeout_o is set (sticky until reset).
    - core_done_i in the same cycle as the timeout condition counts as a normal completion; timeout_o is not set.
  - On completion: last_cycles_o = counter + 1 (saturating), so a done pulse in the first Run cycle gives 1.
    - If the FIFO is not full, or a pop happens in the same cycle, push the feedback and go to Idle.
    - Otherwise go to Stall.
  - Stall: hold the feedback entry; push it on the first cycle the FIFO has space, then go to Idle.
- hpu_task_ready_o = (state == Idle).
  - A task is never accepted in the same cycle a feedback push leaves Run or Stall.
  - Minimum back-to-back task spacing is therefore 3 cycles: accept, ack, done.
- Feedback entry fields:
  - feedback_descr.msgid, pkt_addr and pkt_size are copied from core_task_o.handler_task.
  - pkt_ptr is copied from core_task_o.pkt_ptr.
  - A timed-out handler still produces exactly one feedback entry, so the L1 buffer is always freed.
- Feedback FIFO:
  - hpu_feedback_valid_o = !empty; hpu_feedback_o = head entry.
  - Pop on valid && ready; order is preserved.
  - Push and pop in the same cycle while full is legal.
  - hpu_feedback_o must stay stable while valid is high and no pop occurs (AXI-style), because the upstream arbiter locks in.
- hpu_active_o = (state != Idle) || !FIFO empty.
- core_done_i outside Run is ignored. core_task_ack_i outside Dispatch is ignored.

Test Plan:
- Basic task: accept task with msgid=5, pkt_size=64, pkt_addr=0x1000, pkt_ptr=0x1C0; ack at t+2; done 10 cycles after ack → one feedback with msgid=5, size=64, addr=0x1000, pkt_ptr=0x1C0; last_cycles_o=10; hpu_active_o low after the pop.
- Back-pressure: hold hpu_feedback_ready_i=0; run 3 tasks (FB_FIFO_DEPTH=2) → third completion enters Stall and hpu_task_ready_o stays 0; release ready → feedback arrives in order 1,2,3, each held stable until popped.
- Watchdog: MAX_HANDLER_CYCLES=8, never pulse done → completion after exactly 8 Run cycles; timeout_o=1; last_cycles_o=8; one feedback emitted.
- Done/timeout collision: MAX_HANDLER_CYCLES=8, done in the 8th Run cycle → timeout_o stays 0; last_cycles_o=8.
- Spurious inputs: core_done_i in Idle or Dispatch and core_task_ack_i in Run → no state change, no feedback.
- Reset mid-run: assert rst_ni low during Run with 1 FIFO entry pending → immediately valid outputs=0, ready=1, active=0; no stale feedback after reset is released.

Source files
------------

// File: rtl/hpu_task_frontend.sv
// hpu_task_frontend: per-HPU endpoint between the cluster scheduler and the core runtime.
// Latency: a task is presented to the core one cycle after acceptance; feedback is pushed on the completion cycle.
// Backpressure: a full feedback FIFO parks the frontend in Stall, and no new task is accepted until the entry is pushed.
// Ports:
//   clk_i, rst_ni                          clock, asynchronous active-low reset
//   hpu_task_valid_i/ready_o, hpu_task_i   task in from the cluster scheduler
//   hpu_feedback_valid_o/ready_i, _o       feedback out to the cluster feedback arbiter
//   hpu_active_o                           busy: handler in flight or feedback pending
//   core_task_valid_o, core_task_o         task offered to the core runtime
//   core_task_ack_i, core_done_i           handler start / single-cycle finish pulse
//   timeout_o, last_cycles_o               sticky watchdog flag, duration of the last handler

package hpu_task_frontend_pkg;
  typedef struct packed {
    logic [15:0] msgid;
    logic [31:0] pkt_addr;
    logic [15:0] pkt_size;
  } handler_task_t;

  typedef struct packed {
    handler_task_t handler_task;
    logic [31:0]   pkt_ptr;
  } hpu_handler_task_t;

  typedef struct packed {
    handler_task_t feedback_descr;
    logic [31:0]   pkt_ptr;
  } task_feedback_descr_t;
endpackage

// hpu_fifo: generic synchronous FIFO. head_dat shows the oldest entry.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: a push is taken when the FIFO is not full, or when a pop happens in the same cycle.
module hpu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The head slot is only rewritten by a push when full, and then it is being popped
  // in that same cycle, so head_dat is stable while nothing is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      if (do_push != do_pop) count <= do_push ? count + CW'(1) : count - CW'(1);
    end
  end
endmodule

module hpu_task_frontend
  import hpu_task_frontend_pkg::*;
#(
  parameter int          FB_FIFO_DEPTH      = 2,
  parameter int unsigned MAX_HANDLER_CYCLES = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 hpu_task_valid_i,
  output logic                 hpu_task_ready_o,
  input  hpu_handler_task_t    hpu_task_i,
  output logic                 hpu_feedback_valid_o,
  input  logic                 hpu_feedback_ready_i,
  output task_feedback_descr_t hpu_feedback_o,
  output logic                 hpu_active_o,
  output logic                 core_task_valid_o,
  output hpu_handler_task_t    core_task_o,
  input  logic                 core_task_ack_i,
  input  logic                 core_done_i,
  output logic                 timeout_o,
  output logic [31:0]          last_cycles_o
);
  typedef enum logic [1:0] {IDLE, DISPATCH, RUN, STALL} state_t;

  localparam logic [31:0] WD_LAST = 32'(MAX_HANDLER_CYCLES - 1);

  state_t               state;
  logic [31:0]          cycles, cycles_inc;
  logic                 wd_hit, complete, fb_pop, fb_space, fb_push, fb_full, fb_empty;
  task_feedback_descr_t fb_entry;

  assign cycles_inc = (cycles == '1) ? cycles : cycles + 32'd1;
  assign wd_hit     = (MAX_HANDLER_CYCLES != 0) && (cycles == WD_LAST);
  // A done pulse on the watchdog cycle wins: it completes normally.
  assign complete   = (state == RUN) && (core_done_i || wd_hit);
  assign fb_pop     = hpu_feedback_valid_o && hpu_feedback_ready_i;
  assign fb_space   = !fb_full || fb_pop;
  assign fb_push    = (complete || (state == STALL)) && fb_space;

  // core_task_o is held until the next accept, which cannot happen before the
  // push, so the feedback entry is built straight from it (also while stalled).
  assign fb_entry.feedback_descr = core_task_o.handler_task;
  assign fb_entry.pkt_ptr        = core_task_o.pkt_ptr;

  assign hpu_task_ready_o     = (state == IDLE);
  assign core_task_valid_o    = (state == DISPATCH);
  assign hpu_feedback_valid_o = !fb_empty;
  assign hpu_active_o         = (state != IDLE) || !fb_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      core_task_o   <= '0;
      cycles        <= '0;
      timeout_o     <= 1'b0;
      last_cycles_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hpu_task_valid_i) begin
            core_task_o <= hpu_task_i;
            state       <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (core_task_ack_i) begin
            cycles <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (complete) begin
            last_cycles_o <= cycles_inc;
            if (!core_done_i) timeout_o <= 1'b1;
            state <= fb_space ? IDLE : STALL;
          end else begin
            cycles <= cycles_inc;
          end
        end
        STALL: begin
          if (fb_space) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  hpu_fifo #(
    .DEPTH(FB_FIFO_DEPTH),
    .WIDTH($bits(task_feedback_descr_t))
  ) u_fb_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (fb_push),
    .push_dat (fb_entry),
    .pop      (fb_pop),
    .head_dat (hpu_feedback_o),
    .full     (fb_full),
    .empty    (fb_empty)
  );
endmodule
